// File: rtl/enybul_app_pkg.sv
// Shared tank definitions: facing codes, arena bounds, bullet FSM states and
// small position helpers. The tank controllers use the same direction codes
// and arena bounds.
package enybul_app_pkg;

  // Facing codes as driven on tank_dir_out
  localparam logic [1:0] DIR_UP    = 2'b00;  // y-1
  localparam logic [1:0] DIR_DOWN  = 2'b01;  // y+1
  localparam logic [1:0] DIR_LEFT  = 2'b10;  // x-1
  localparam logic [1:0] DIR_RIGHT = 2'b11;  // x+1

  // Arena bounds (inclusive last column / row)
  localparam int unsigned ARENA_X_MAX = 16;
  localparam int unsigned ARENA_Y_MAX = 20;

  typedef logic [4:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FLY  = 2'b01,
    ST_COOL = 2'b10
  } bul_state_t;

  // True when one more step in dir would leave the arena.
  function automatic logic at_edge(pos_t p, logic [1:0] dir, coord_t xm, coord_t ym);
    logic r;
    case (dir)
      DIR_UP:   r = (p.y == '0);
      DIR_DOWN: r = (p.y == ym);
      DIR_LEFT: r = (p.x == '0);
      default:  r = (p.x == xm);
    endcase
    return r;
  endfunction

  // One grid cell in dir; callers guarantee the move stays inside the arena.
  function automatic pos_t move_one(pos_t p, logic [1:0] dir);
    pos_t n;
    n = p;
    case (dir)
      DIR_UP:   n.y = p.y - 5'd1;
      DIR_DOWN: n.y = p.y + 5'd1;
      DIR_LEFT: n.x = p.x - 5'd1;
      default:  n.x = p.x + 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/enybul_app_if.sv
// Tank-controller / display side bundle of the enemy bullet engine.
//   master : tank controller + display (drives fire/positions, reads bullet)
//   slave  : bullet engine
//   enybul_state, tank_state          fire request, owning tank alive
//   enytank_xpos/ypos, tank_dir_out   launching tank position and facing
//   mytank_xpos/ypos                  player tank position
//   enybul_state_feedback             bullet busy (FLY or COOL)
//   enybul_vis, enybul_x, enybul_y    bullet drawing data
//   mytank_hit                        one-clk pulse on player hit
interface enybul_app_if;
  import enybul_app_pkg::*;

  logic       enybul_state;
  logic       tank_state;
  coord_t     enytank_xpos;
  coord_t     enytank_ypos;
  logic [1:0] tank_dir_out;
  coord_t     mytank_xpos;
  coord_t     mytank_ypos;
  logic       enybul_state_feedback;
  logic       enybul_vis;
  coord_t     enybul_x;
  coord_t     enybul_y;
  logic       mytank_hit;

  modport master (
    output enybul_state, tank_state, enytank_xpos, enytank_ypos, tank_dir_out,
           mytank_xpos, mytank_ypos,
    input  enybul_state_feedback, enybul_vis, enybul_x, enybul_y, mytank_hit
  );

  modport slave (
    input  enybul_state, tank_state, enytank_xpos, enytank_ypos, tank_dir_out,
           mytank_xpos, mytank_ypos,
    output enybul_state_feedback, enybul_vis, enybul_x, enybul_y, mytank_hit
  );

endinterface

// File: rtl/enybul_app_step_sync.sv
// Brings a slow square wave (used as data) into the clk domain through
// SYNC_STAGES flops (must be >= 2) and emits a one-clk pulse on each rising
// edge of the synchronised level.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : slow asynchronous level (e.g. clk_8Hz)
//   step     : one-clk pulse per rising edge of din
module enybul_app_step_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic step
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/enybul_app.sv
// Enemy-tank bullet engine. Launches one bullet from the enemy tank on a fire
// request, moves it one cell per 8 Hz step, retires it at the arena edge or
// on striking the player tank, then holds busy for COOL_TICKS steps.
//   clk, rst  : system clock, asynchronous active-high reset
//   clk_8Hz   : 8 Hz square wave, sampled as data
//   bus       : enybul_app_if.slave (fire/positions in, bullet state out)
module enybul_app
  import enybul_app_pkg::*;
#(
  parameter int unsigned X_MAX       = ARENA_X_MAX,
  parameter int unsigned Y_MAX       = ARENA_Y_MAX,
  parameter int unsigned COOL_TICKS  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_8Hz,
  enybul_app_if.slave  bus
);

  localparam int unsigned CNT_W = (COOL_TICKS < 1) ? 1 : $clog2(COOL_TICKS + 1);
  localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOL_TICKS);
  localparam coord_t XM = coord_t'(X_MAX);
  localparam coord_t YM = coord_t'(Y_MAX);

  bul_state_t       state_q;
  logic [1:0]       dir_q;
  pos_t             pos_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fb_q;
  logic             vis_q;
  logic             hit_q;

  logic step;
  logic edge_now;
  pos_t cand;
  logic hit_now;

  enybul_app_step_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_step_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_8Hz),
    .step (step)
  );

  // Candidate cell for this clk: moved on a step not blocked by the edge,
  // otherwise the current cell. Checking the current cell on non-step clks
  // covers both the launch-cell overlap and a player walking onto a
  // stationary bullet.
  always_comb begin
    edge_now = at_edge(pos_q, dir_q, XM, YM);
    cand     = pos_q;
    if (step && !edge_now) begin
      cand = move_one(pos_q, dir_q);
    end
    hit_now = !(step && edge_now) &&
              (cand == pos_t'{x: bus.mytank_xpos, y: bus.mytank_ypos});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      pos_q   <= '0;
      cnt_q   <= '0;
      fb_q    <= 1'b0;
      vis_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.enybul_state && bus.tank_state) begin
            state_q <= ST_FLY;
            pos_q   <= pos_t'{x: bus.enytank_xpos, y: bus.enytank_ypos};
            dir_q   <= bus.tank_dir_out;
            fb_q    <= 1'b1;
            vis_q   <= 1'b1;
          end
        end

        ST_FLY: begin
          pos_q <= cand;
          if (hit_now || (step && edge_now)) begin
            hit_q <= hit_now;
            vis_q <= 1'b0;
            if (COOL_TICKS == 0) begin
              state_q <= ST_IDLE;
              fb_q    <= 1'b0;
            end else begin
              state_q <= ST_COOL;
              cnt_q   <= COOL_INIT;
            end
          end
        end

        ST_COOL: begin
          if (step) begin
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              fb_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          fb_q    <= 1'b0;
          vis_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enybul_state_feedback = fb_q;
  assign bus.enybul_vis            = vis_q;
  assign bus.enybul_x              = pos_q.x;
  assign bus.enybul_y              = pos_q.y;
  assign bus.mytank_hit            = hit_q;

endmodule

// File: tb/tb_enybul_app.sv
// Directed bench for enybul_app: a table of single flights with hand-computed
// outcomes plus hand sequences for hold-fire, mid-flight reset, launch/step
// coincidence, tank death in flight and player-walks-onto-bullet.
module tb_enybul_app;
  import enybul_app_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clk_8Hz;

  enybul_app_if bus();

  enybul_app #(
    .X_MAX       (16),
    .Y_MAX       (20),
    .COOL_TICKS  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_8Hz (clk_8Hz),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hit_cnt = 0;

  // hit pulses are registered after posedge; one negedge sample per clk high
  always @(negedge clk) if (bus.mytank_hit) hit_cnt++;

  typedef struct {
    logic [4:0] tx, ty;
    logic [1:0] dir;
    logic [4:0] px, py;
    int         n_steps;   // steps until bullet disappears
    logic [4:0] ex, ey;    // final (held) bullet cell
    int         hits;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    clk_8Hz = 1'b1;
    repeat (4) tick();
    clk_8Hz = 1'b0;
    repeat (4) tick();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fire_once();
    bus.enybul_state = 1'b1;
    tick();
    bus.enybul_state = 1'b0;
  endtask

  task automatic set_tank(input int x, input int y, input logic [1:0] d);
    bus.enytank_xpos = 5'(x);
    bus.enytank_ypos = 5'(y);
    bus.tank_dir_out = d;
  endtask

  task automatic set_player(input int x, input int y);
    bus.mytank_xpos = 5'(x);
    bus.mytank_ypos = 5'(y);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int oob;
    vec_t v;

    //            tx  ty  dir        px  py  n  ex  ey  hits
    vecs[0] = '{5'd5,  5'd5,  DIR_RIGHT, 5'd9,  5'd5,  4, 5'd9,  5'd5,  1};
    vecs[1] = '{5'd16, 5'd3,  DIR_RIGHT, 5'd31, 5'd31, 1, 5'd16, 5'd3,  0};
    vecs[2] = '{5'd0,  5'd20, DIR_DOWN,  5'd31, 5'd31, 1, 5'd0,  5'd20, 0};
    vecs[3] = '{5'd3,  5'd2,  DIR_UP,    5'd31, 5'd31, 3, 5'd3,  5'd0,  0};
    vecs[4] = '{5'd2,  5'd7,  DIR_LEFT,  5'd0,  5'd7,  2, 5'd0,  5'd7,  1};
    vecs[5] = '{5'd4,  5'd4,  DIR_DOWN,  5'd4,  5'd4,  0, 5'd4,  5'd4,  1};
    vecs[6] = '{5'd14, 5'd18, DIR_RIGHT, 5'd31, 5'd31, 3, 5'd16, 5'd18, 0};
    vecs[7] = '{5'd10, 5'd19, DIR_DOWN,  5'd31, 5'd31, 2, 5'd10, 5'd20, 0};

    rst = 1'b1;
    clk_8Hz = 1'b0;
    bus.enybul_state = 1'b0;
    bus.tank_state   = 1'b1;
    set_tank(0, 0, DIR_UP);
    set_player(31, 31);
    tick();
    tick();
    chk("rst_fb",  bus.enybul_state_feedback, 0);
    chk("rst_vis", bus.enybul_vis, 0);
    chk("rst_x",   bus.enybul_x, 0);
    chk("rst_y",   bus.enybul_y, 0);
    chk("rst_hit", bus.mytank_hit, 0);
    rst = 1'b0;
    tick();

    // dead tank cannot fire
    bus.tank_state = 1'b0;
    set_tank(5, 5, DIR_RIGHT);
    bus.enybul_state = 1'b1;
    tick();
    tick();
    bus.enybul_state = 1'b0;
    chk("dead_tank_no_fire", bus.enybul_state_feedback, 0);
    bus.tank_state = 1'b1;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      set_tank(v.tx, v.ty, v.dir);
      set_player(v.px, v.py);
      base = hit_cnt;
      fire_once();
      chk($sformatf("v%0d_launch_x", i), bus.enybul_x, v.tx);
      chk($sformatf("v%0d_launch_y", i), bus.enybul_y, v.ty);
      chk($sformatf("v%0d_launch_fb", i), bus.enybul_state_feedback, 1);
      chk($sformatf("v%0d_launch_vis", i), bus.enybul_vis, 1);
      tick();
      tick();
      n = 0;
      oob = 0;
      while (bus.enybul_vis && n < 30) begin
        do_step();
        n++;
        if (bus.enybul_x > 5'd16 || bus.enybul_y > 5'd20) oob++;
      end
      chk($sformatf("v%0d_steps", i), n, v.n_steps);
      chk($sformatf("v%0d_x", i), bus.enybul_x, v.ex);
      chk($sformatf("v%0d_y", i), bus.enybul_y, v.ey);
      chk($sformatf("v%0d_hits", i), hit_cnt - base, v.hits);
      chk($sformatf("v%0d_oob", i), oob, 0);
      chk($sformatf("v%0d_cool_fb", i), bus.enybul_state_feedback, 1);
      do_step();
      chk($sformatf("v%0d_cool1_fb", i), bus.enybul_state_feedback, 1);
      do_step();
      chk($sformatf("v%0d_idle_fb", i), bus.enybul_state_feedback, 0);
      chk($sformatf("v%0d_hits_after", i), hit_cnt - base, v.hits);
    end

    // fire held through FLY and COOL: no relaunch until IDLE
    set_player(31, 31);
    set_tank(5, 1, DIR_UP);
    bus.enybul_state = 1'b1;
    tick();
    set_tank(8, 8, DIR_DOWN);
    tick();
    chk("hold_x0", bus.enybul_x, 5);
    chk("hold_y0", bus.enybul_y, 1);
    do_step();
    chk("hold_y1", bus.enybul_y, 0);
    chk("hold_x1", bus.enybul_x, 5);
    do_step();
    chk("hold_retire_vis", bus.enybul_vis, 0);
    chk("hold_retire_fb", bus.enybul_state_feedback, 1);
    do_step();
    chk("hold_cool_vis", bus.enybul_vis, 0);
    chk("hold_cool_x", bus.enybul_x, 5);
    do_step();
    chk("hold_relaunch_vis", bus.enybul_vis, 1);
    chk("hold_relaunch_x", bus.enybul_x, 8);
    chk("hold_relaunch_y", bus.enybul_y, 8);
    bus.enybul_state = 1'b0;
    do_reset();

    // reset mid-flight
    set_tank(5, 5, DIR_RIGHT);
    fire_once();
    do_step();
    do_step();
    chk("mid_x7", bus.enybul_x, 7);
    rst = 1'b1;
    tick();
    chk("mid_rst_fb", bus.enybul_state_feedback, 0);
    chk("mid_rst_vis", bus.enybul_vis, 0);
    chk("mid_rst_x", bus.enybul_x, 0);
    chk("mid_rst_y", bus.enybul_y, 0);
    rst = 1'b0;
    tick();
    set_tank(2, 2, DIR_DOWN);
    fire_once();
    chk("post_rst_x", bus.enybul_x, 2);
    chk("post_rst_fb", bus.enybul_state_feedback, 1);
    do_step();
    chk("post_rst_y3", bus.enybul_y, 3);
    do_reset();

    // launch on the clk carrying the step pulse; tank dies in flight
    set_tank(12, 6, DIR_RIGHT);
    set_player(15, 6);
    base = hit_cnt;
    clk_8Hz = 1'b1;
    tick();               // first sync flop
    tick();               // second sync flop: step pulse is now high
    bus.enybul_state = 1'b1;
    tick();               // launch and step together
    bus.enybul_state = 1'b0;
    chk("coinc_launch_x", bus.enybul_x, 12);
    chk("coinc_launch_vis", bus.enybul_vis, 1);
    tick();
    tick();
    clk_8Hz = 1'b0;
    repeat (4) tick();
    chk("coinc_no_move", bus.enybul_x, 12);
    bus.tank_state = 1'b0;
    do_step();
    chk("dead_x13", bus.enybul_x, 13);
    do_step();
    chk("dead_x14", bus.enybul_x, 14);
    do_step();
    chk("dead_x15", bus.enybul_x, 15);
    chk("dead_hit", hit_cnt - base, 1);
    chk("dead_vis", bus.enybul_vis, 0);
    do_step();
    do_step();
    chk("dead_idle_fb", bus.enybul_state_feedback, 0);
    bus.tank_state = 1'b1;

    // player walks onto a stationary bullet; no hits outside FLY
    set_tank(6, 12, DIR_LEFT);
    set_player(31, 31);
    fire_once();
    tick();
    tick();
    base = hit_cnt;
    set_player(6, 12);
    tick();
    tick();
    chk("walk_on_hit", hit_cnt - base, 1);
    chk("walk_on_vis", bus.enybul_vis, 0);
    repeat (3) tick();
    chk("cool_no_hit", hit_cnt - base, 1);
    do_step();
    do_step();
    chk("walk_idle_fb", bus.enybul_state_feedback, 0);
    repeat (3) tick();
    chk("idle_no_hit", hit_cnt - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
